fetch_pc_unit: RTL

Instruction-fetch stage of the RV32 pipeline. It holds the program counter, drives the instruction-memory address, and registers the fetched instruction and its PC into the IF/ID pipeline register. It consumes the redirect produced by the EX-stage branch unit (`BrPC`/`PcSel`) and the stall from the hazard unit. The PC it registers is the `Cur_PC` that flows down the pipe back to the branch unit.

---
 rtl/fetch_pc_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Purpose: RV32 fetch stage: holds the PC, drives imem address, registers instr+PC into IF/ID.
// Latency: instruction at PC=A appears in IF/ID one cycle later; a redirect costs one bubble.
// Backpressure: Stall holds PC and IF/ID bit-identical; a redirect (PcSel) overrides Stall.
// Optional feature: define HALT_DETECT_EN to freeze fetch after an ebreak enters IF/ID.
module fetch_pc_unit #(
   parameter int          PC_W      = 9,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Stall,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic [31:0]     InstrIn,
   output logic [PC_W-1:0] PC,
   output logic [PC_W-1:0] IfId_PC,
   output logic [31:0]     IfId_Instr,
   output logic            IfId_Valid,
   output logic            MisalignErr,
   output logic            Halted
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] redirect_pc;
   logic            load_ifid;

   // Upper BrPC bits beyond the PC width are dropped; low two bits forced to word alignment.
   assign redirect_pc = {BrPC[PC_W-1:2], 2'b00};

   // IF/ID captures a new instruction only on a plain advancing cycle.
   assign load_ifid = !PcSel && !Stall && !Halted;

   // Next-PC selection; a redirect still lands while halted so the flush has a target.
   always_comb begin
      pc_next = PC;
      if (PcSel)
         pc_next = redirect_pc;
      else if (!Stall && !Halted)
         pc_next = PC + PC_W'(4);
   end

   // PC and IF/ID pipeline register; flush on redirect, hold on stall/halt, else load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PC         <= '0;
         IfId_PC    <= '0;
         IfId_Instr <= NOP_INSTR;
         IfId_Valid <= 1'b0;
      end else begin
         PC <= pc_next;
         if (PcSel) begin
            IfId_PC    <= '0;
            IfId_Instr <= NOP_INSTR;
            IfId_Valid <= 1'b0;
         end else if (load_ifid) begin
            IfId_PC    <= PC;
            IfId_Instr <= InstrIn;
            IfId_Valid <= 1'b1;
         end
      end
   end

   // Sticky misalignment flag, raised by any taken redirect with nonzero low bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         MisalignErr <= 1'b0;
      else if (PcSel && (BrPC[1:0] != 2'b00))
         MisalignErr <= 1'b1;
   end

`ifdef HALT_DETECT_EN
   logic halt_q;

   // Sticky halt, set on the same edge an ebreak is loaded into IF/ID; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         halt_q <= 1'b0;
      else if (load_ifid && (InstrIn == EBREAK))
         halt_q <= 1'b1;
   end

   assign Halted = halt_q;
`else
   logic unused_ebreak;
   assign unused_ebreak = ^EBREAK;
   assign Halted        = 1'b0;
`endif

   logic unused_brpc;
   assign unused_brpc = ^BrPC;

endmodule
